// File: rtl/fetch_stall_ctrl.sv
// fetch_stall_ctrl: decides when the fetch/decode front end of the pipeline
// must stall. Stalls come from register read-after-write hazards (Tuse/Tnew)
// and from the iterative multiply/divide unit being busy.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   d_rs, d_rt               source registers of the instruction in D
//   d_rs_tuse, d_rt_tuse     cycles until D needs rs/rt (3 = operand unused)
//   d_md_use                 D instruction uses the mult/div unit
//   e_wa, m_wa               destination registers in E / M (0 = no write)
//   e_tnew, m_tnew           cycles until the E / M result is ready
//   e_md_start, e_md_op      mult/div starts in E (op: 0 = mult, 1 = div)
//   pc_en, fd_en             PC and F/D write enables (combinational)
//   de_flush                 bubble into D/E (combinational)
//   md_busy                  mult/div unit busy (registered)
//   stall_cnt                saturating count of stalled cycles (registered)
module fetch_stall_ctrl #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_rs_tuse,
  input  logic [1:0]  d_rt_tuse,
  input  logic        d_md_use,
  input  logic [4:0]  e_wa,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  e_tnew,
  input  logic [1:0]  m_tnew,
  input  logic        e_md_start,
  input  logic        e_md_op,
  output logic        pc_en,
  output logic        fd_en,
  output logic        de_flush,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SCNT_W = 32;
  localparam logic [1:0]  TUSE_NONE = 2'd3;

  logic [CNT_W-1:0]  md_cnt;
  logic [CNT_W-1:0]  md_cnt_nxt;
  logic [SCNT_W-1:0] stall_cnt_nxt;
  logic              rs_haz;
  logic              rt_haz;
  logic              md_haz;
  logic              stall;

  // Register RAW hazards: a producer whose result arrives later than the
  // consumer needs it. r0 never hazards; Tuse=3 can never be exceeded.
  always_comb begin
    rs_haz = 1'b0;
    rt_haz = 1'b0;
    if ((d_rs != 5'd0) && (d_rs_tuse != TUSE_NONE)) begin
      rs_haz = ((d_rs == e_wa) && (e_tnew > d_rs_tuse)) ||
               ((d_rs == m_wa) && (m_tnew > d_rs_tuse));
    end
    if ((d_rt != 5'd0) && (d_rt_tuse != TUSE_NONE)) begin
      rt_haz = ((d_rt == e_wa) && (e_tnew > d_rt_tuse)) ||
               ((d_rt == m_wa) && (m_tnew > d_rt_tuse));
    end
  end

  // Mult/div terms are masked while reset is held.
  always_comb begin
    md_haz = d_md_use && (e_md_start || md_busy) && !reset;
    stall  = rs_haz || rt_haz || md_haz;
  end

  assign pc_en    = ~stall;
  assign fd_en    = ~stall;
  assign de_flush = stall;

  // Busy counter: a new start always reloads, otherwise count down to 0.
  always_comb begin
    md_cnt_nxt = md_cnt;
    if (e_md_start) begin
      md_cnt_nxt = e_md_op ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (md_cnt != '0) begin
      md_cnt_nxt = md_cnt - CNT_W'(1);
    end
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_nxt = stall_cnt;
    if (stall && (stall_cnt != '1)) begin
      stall_cnt_nxt = stall_cnt + SCNT_W'(1);
    end
  end

  // State registers; md_busy mirrors the counter value after each edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt    <= '0;
      md_busy   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      md_cnt    <= md_cnt_nxt;
      md_busy   <= (md_cnt_nxt != '0);
      stall_cnt <= stall_cnt_nxt;
    end
  end

endmodule

// File: doc/fetch_stall_ctrl.md
FETCH_STALL_CTRL -- requirements
Module: fetch_stall_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5: busy cycles after a multiply starts (1..15).
REQ-002 Parameter DIV_CYC, default 10: busy cycles after a divide starts (1..15).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 d_rs, d_rt  input  5 each  source register fields of the instruction in D.
REQ-006 d_rs_tuse, d_rt_tuse  input  2 each  cycles until D needs rs/rt; 3 = operand not used.
REQ-007 d_md_use  input  1  D instruction uses the mult/div unit (mult/div/mfhi/mflo/mthi/mtlo).
REQ-008 e_wa, m_wa  input  5 each  destination register in E / M; 0 = no write.
REQ-009 e_tnew, m_tnew  input  2 each  cycles until the E / M result is available.
REQ-010 e_md_start  input  1  mult/div instruction in E this cycle.
REQ-011 e_md_op  input  1  0 = multiply, 1 = divide; valid with e_md_start.
REQ-012 pc_en  output  1  PC register write enable.
REQ-013 fd_en  output  1  F/D pipeline register write enable.
REQ-014 de_flush  output  1  insert bubble into D/E register.
REQ-015 md_busy  output  1  mult/div unit busy.
REQ-016 stall_cnt  output  32  total stalled cycles since reset.

Function
REQ-017 The block SHALL compute rs_haz = (d_rs!=0) & ((d_rs==e_wa & e_tnew>d_rs_tuse) | (d_rs==m_wa & m_tnew>d_rs_tuse)); rt_haz likewise with d_rt/d_rt_tuse.
REQ-018 Tuse = 3 SHALL never cause a stall, whatever Tnew is.
REQ-019 Register 0 SHALL never cause a stall, even if e_wa or m_wa is 0.
REQ-020 md_cnt (4-bit) SHALL load MULT_CYC on a clock edge where e_md_start=1 and e_md_op=0, and DIV_CYC where e_md_op=1.
REQ-021 Otherwise md_cnt SHALL decrement by 1 each edge while nonzero, and hold at 0.
REQ-022 md_busy SHALL equal (md_cnt!=0), registered: high for exactly N cycles following the e_md_start cycle.
REQ-023 md_haz SHALL be d_md_use & (e_md_start | md_busy).
REQ-024 e_md_start while md_cnt!=0 SHALL reload the counter; the newer start wins.
REQ-025 stall SHALL be rs_haz | rt_haz | md_haz, purely combinational, same cycle.
REQ-026 pc_en = fd_en = ~stall; de_flush = stall.
REQ-027 When stall=1, F and D SHALL hold, and E SHALL receive a bubble.
REQ-028 Stall resolution SHALL need no memory of prior stalls beyond md_cnt; stall drops the cycle the condition clears.
REQ-029 stall_cnt SHALL increment on each edge where stall=1, and saturate at 32'hFFFF_FFFF.
REQ-030 If several hazards are active in one cycle, the block SHALL count one stall cycle.

Reset
REQ-031 On reset assertion, md_cnt=0, md_busy=0 and stall_cnt=0 SHALL take effect immediately, without waiting for clk.
REQ-032 During reset, pc_en, fd_en and de_flush SHALL follow combinational inputs with md terms forced 0.
REQ-033 Reset asserted mid-divide SHALL abort the busy window; first edge after release sees md_busy=0.

Verification
REQ-034 Load-use: d_rs=8, d_rs_tuse=1, e_wa=8, e_tnew=2 -> stall=1, pc_en=0, de_flush=1. Next cycle e_wa=0, m_wa=8, m_tnew=1 -> stall=0.
REQ-035 Tuse/zero: d_rt=0 with e_wa=0, e_tnew=2 -> stall=0. d_rs=5, d_rs_tuse=3, e_wa=5, e_tnew=2 -> stall=0.
REQ-036 Divide: e_md_start=1, e_md_op=1 at cycle t -> md_busy=1 for cycles t+1..t+10 and 0 at t+11. With d_md_use=1 throughout, stall is high for t..t+10, giving stall_cnt=11.
REQ-037 Multiply (MULT_CYC=5): with d_md_use=0 -> stall stays 0 while md_busy=1 for 5 cycles. Then d_md_use=1 at busy cycle 3 -> stall for 3 cycles.
REQ-038 Reset mid-op: async reset at busy cycle 4 of a divide -> md_busy=0 and stall_cnt=0 before the next clk edge.
REQ-039 Saturation: preload stall_cnt to 32'hFFFF_FFFE (force), then hold stall for 3 cycles -> stall_cnt stays 32'hFFFF_FFFF.
